// File: rtl/execute_stage_p.sv
// Execute stage: E pipeline register, ALU, condition codes and
// branch/cmov condition evaluation, plus the M pipeline register.
module execute_stage_p #(
   parameter int XLEN    = 64,
   parameter int SP_STEP = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            e_stall,
   input  logic            e_bubble,
   input  logic            m_bubble,
   input  logic            w_exc,
   input  logic [2:0]      d_stat,
   input  logic [3:0]      d_icode,
   input  logic [3:0]      d_ifun,
   input  logic [XLEN-1:0] d_valA,
   input  logic [XLEN-1:0] d_valB,
   input  logic [XLEN-1:0] d_valC,
   input  logic [3:0]      d_dstE,
   input  logic [3:0]      d_dstM,
   output logic            e_cnd,
   output logic [XLEN-1:0] e_valE,
   output logic [3:0]      e_dstE,
   output logic [2:0]      cc,
   output logic [2:0]      m_stat,
   output logic [3:0]      m_icode,
   output logic            m_cnd,
   output logic [XLEN-1:0] m_valE,
   output logic [XLEN-1:0] m_valA,
   output logic [3:0]      m_dstE,
   output logic [3:0]      m_dstM
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOV   = 4'h2;
   localparam logic [3:0] I_IRMOV  = 4'h3;
   localparam logic [3:0] I_RMMOV  = 4'h4;
   localparam logic [3:0] I_MRMOV  = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSH   = 4'hA;
   localparam logic [3:0] I_POP    = 4'hB;
   localparam logic [3:0] R_NONE   = 4'hF;
   localparam logic [2:0] CC_RST   = 3'b100;
   localparam logic [XLEN-1:0] SP  = XLEN'(SP_STEP);

   typedef struct packed {
      logic [2:0]      stat;
      logic [3:0]      icode;
      logic [3:0]      ifun;
      logic [XLEN-1:0] val_a;
      logic [XLEN-1:0] val_b;
      logic [XLEN-1:0] val_c;
      logic [3:0]      dst_e;
      logic [3:0]      dst_m;
   } ereg_t;

   typedef struct packed {
      logic [2:0]      stat;
      logic [3:0]      icode;
      logic            cnd;
      logic [XLEN-1:0] val_e;
      logic [XLEN-1:0] val_a;
      logic [3:0]      dst_e;
      logic [3:0]      dst_m;
   } mreg_t;

   localparam ereg_t E_BUB = '{
      stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
      val_a: '0, val_b: '0, val_c: '0,
      dst_e: R_NONE, dst_m: R_NONE
   };

   localparam mreg_t M_BUB = '{
      stat: STAT_AOK, icode: I_NOP, cnd: 1'b0,
      val_e: '0, val_a: '0,
      dst_e: R_NONE, dst_m: R_NONE
   };

   ereg_t           e_q, e_d;
   mreg_t           m_q, m_d;
   logic [2:0]      cc_q, cc_d;
   logic [XLEN-1:0] alu_res;
   logic            alu_of;
   logic            zf, sf, of;
   logic            sa, sb, sr;

   // ALU: operation selected by ifun, overflow from operand/result signs
   always_comb begin
      alu_res = '0;
      alu_of  = 1'b0;
      sa      = e_q.val_a[XLEN-1];
      sb      = e_q.val_b[XLEN-1];
      unique case (e_q.ifun)
         4'h0: alu_res = e_q.val_b + e_q.val_a;
         4'h1: alu_res = e_q.val_b - e_q.val_a;
         4'h2: alu_res = e_q.val_b & e_q.val_a;
         4'h3: alu_res = e_q.val_b ^ e_q.val_a;
         default: alu_res = '0;
      endcase
      sr = alu_res[XLEN-1];
      if (e_q.ifun == 4'h0)
         alu_of = (sa == sb) && (sr != sb);
      else if (e_q.ifun == 4'h1)
         alu_of = (sa != sb) && (sr != sb);
   end

   // Result mux by instruction class
   always_comb begin
      e_valE = '0;
      unique case (e_q.icode)
         I_CMOV:          e_valE = e_q.val_a;
         I_IRMOV:         e_valE = e_q.val_c;
         I_RMMOV, I_MRMOV: e_valE = e_q.val_b + e_q.val_c;
         I_OPQ:           e_valE = alu_res;
         I_CALL, I_PUSH:  e_valE = e_q.val_b - SP;
         I_RET, I_POP:    e_valE = e_q.val_b + SP;
         default:         e_valE = '0;
      endcase
   end

   // Condition from the registered flags; cancelled cmov drops its dstE
   always_comb begin
      zf    = cc_q[2];
      sf    = cc_q[1];
      of    = cc_q[0];
      e_cnd = 1'b0;
      if (e_q.icode == I_CMOV || e_q.icode == I_JXX) begin
         unique case (e_q.ifun)
            4'h0: e_cnd = 1'b1;
            4'h1: e_cnd = (sf ^ of) | zf;
            4'h2: e_cnd = sf ^ of;
            4'h3: e_cnd = zf;
            4'h4: e_cnd = !zf;
            4'h5: e_cnd = !(sf ^ of);
            4'h6: e_cnd = !(sf ^ of) && !zf;
            default: e_cnd = 1'b0;
         endcase
      end
      e_dstE = e_q.dst_e;
      if (e_q.icode == I_CMOV && !e_cnd)
         e_dstE = R_NONE;
   end

   // Next-state for E, M and the flags
   always_comb begin
      e_d = '{
         stat: d_stat, icode: d_icode, ifun: d_ifun,
         val_a: d_valA, val_b: d_valB, val_c: d_valC,
         dst_e: d_dstE, dst_m: d_dstM
      };
      if (e_bubble)
         e_d = E_BUB;
      else if (e_stall)
         e_d = e_q;
      m_d = '{
         stat: e_q.stat, icode: e_q.icode, cnd: e_cnd,
         val_e: e_valE, val_a: e_q.val_a,
         dst_e: e_dstE, dst_m: e_q.dst_m
      };
      if (m_bubble)
         m_d = M_BUB;
      cc_d = cc_q;
      if (e_q.icode == I_OPQ && e_q.ifun <= 4'd3 &&
          m_q.stat == STAT_AOK && !w_exc)
         cc_d = {alu_res == '0, alu_res[XLEN-1], alu_of};
   end

   // Pipeline registers and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q  <= E_BUB;
         m_q  <= M_BUB;
         cc_q <= CC_RST;
      end else begin
         e_q  <= e_d;
         m_q  <= m_d;
         cc_q <= cc_d;
      end
   end

   assign cc      = cc_q;
   assign m_stat  = m_q.stat;
   assign m_icode = m_q.icode;
   assign m_cnd   = m_q.cnd;
   assign m_valE  = m_q.val_e;
   assign m_valA  = m_q.val_a;
   assign m_dstE  = m_q.dst_e;
   assign m_dstM  = m_q.dst_m;

endmodule

// File: doc/execute_stage_p.md
EXECUTE_STAGE_P -- requirements
Module: execute_stage_p

Interface
REQ-001 SHALL provide parameter XLEN, 64, data-path width in bits for all valA/valB/valC/valE buses.
REQ-002 SHALL provide parameter SP_STEP, 8, stack-pointer adjustment applied by call/push/ret/pop.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 e_stall  in  1  hold E register.
REQ-007 e_bubble  in  1  load NOP bubble into E register.
REQ-008 m_bubble  in  1  load NOP bubble into M register.
REQ-009 w_exc  in  1  writeback stage holds an exception; inhibits CC update.
REQ-010 d_stat  in  3  decode status (AOK=1, HLT=2, ADR=3, INS=4).
REQ-011 d_icode  in  4  decode icode.
REQ-012 d_ifun  in  4  decode ifun.
REQ-013 d_valA  in  XLEN  operand A.
REQ-014 d_valB  in  XLEN  operand B.
REQ-015 d_valC  in  XLEN  constant.
REQ-016 d_dstE  in  4  E destination register (0xF = none).
REQ-017 d_dstM  in  4  M destination register.
REQ-018 e_cnd  out  1  combinational condition result of instruction in E.
REQ-019 e_valE  out  XLEN  combinational ALU result (forwarding source).
REQ-020 e_dstE  out  4  combinational effective dstE (forwarding source).
REQ-021 cc  out  3  registered {ZF,SF,OF}.
REQ-022 m_stat, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM  out  3/4/1/XLEN/XLEN/4/4  M register contents.

Function
REQ-023 E register SHALL capture all d_* inputs on posedge when e_stall=0 and e_bubble=0; hold when e_stall=1; load bubble when e_bubble=1 (bubble wins over stall).
REQ-024 Bubble SHALL be stat=1, icode=1 (NOP), ifun=0, values 0, dstE=dstM=0xF, cnd=0.
REQ-025 M register SHALL capture {E stat, icode, e_cnd, e_valE, E valA, e_dstE, E dstM} every posedge, or bubble when m_bubble=1; latency d_* to m_* = 2 cycles.
REQ-026 e_valE by icode: 2 cmov -> valA; 3 irmov -> valC; 4/5 rmmov/mrmov -> valB+valC; 6 OPq -> ALU; 8/A call/push -> valB-SP_STEP; 9/B ret/pop -> valB+SP_STEP; others -> 0; all arithmetic modulo 2^XLEN.
REQ-027 ALU ifun: 0 valB+valA; 1 valB-valA; 2 valB&valA; 3 valB^valA; other ifun -> result 0, CC not updated.
REQ-028 Flags: ZF=(result==0); SF=result[XLEN-1]; OF add = sign(A)==sign(B) && sign(R)!=sign(B); OF sub = sign(A)!=sign(B) && sign(R)!=sign(B); OF=0 for and/xor.
REQ-029 cc SHALL load new flags on posedge only when E icode=6, ifun<=3, m_stat==AOK and w_exc=0; otherwise hold.
REQ-030 e_cnd for icode 2/7 SHALL use registered cc: ifun 0 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; ifun>6 0; other icodes 0.
REQ-031 e_dstE SHALL be 0xF when icode=2 and e_cnd=0, else E dstE.
REQ-032 OPq followed immediately by cmov/jxx SHALL see flags of that OPq (cc registered at the OPq's E-exit edge).

Reset
REQ-033 rst_n=0 SHALL immediately (no clock) set E and M registers to bubble and cc={1,0,0}; outputs derived accordingly (e_valE=0, e_dstE=0xF, e_cnd=0).
REQ-034 Reset asserted mid-operation SHALL discard in-flight instructions; first capture after release on next posedge with rst_n=1.

Verification
REQ-035 Pulse rst_n low between edges -> m_icode=1, m_stat=1, m_dstE=0xF, cc=3'b100 before next edge.
REQ-036 icode 6 ifun 1, valA=5, valB=3 -> after edge 1 e_valE=0xFFFF_FFFF_FFFF_FFFE; after edge 2 m_valE same, cc=3'b010.
REQ-037 icode 6 ifun 0, valA=valB=0x7FFF_FFFF_FFFF_FFFF -> e_valE=0xFFFF_FFFF_FFFF_FFFE, cc=3'b011 after following edge.
REQ-038 xorq valA=valB=7 then cmovne dstE=3 -> e_cnd=0, e_dstE=0xF; cmove dstE=3 -> e_cnd=1, e_dstE=3.
REQ-039 OPq in E with m_stat=3 (ADR) or w_exc=1 -> cc unchanged after edge.
REQ-040 pushq valB=0x100 with e_stall=1 two cycles -> e_valE=0xF8 held; then e_bubble=1 -> e_valE=0, next m_icode=1.
